// File: rtl/mult4_seq_ctrl_pkg.sv
// rtl/mult4_seq_ctrl_pkg.sv - shared constants for the sequential shift-add multiplier
package mult4_seq_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fourRippleCarryAdder.sv
// rtl/fourRippleCarryAdder.sv - bit-serial-carry ripple adder, WIDTH bits wide
module fourRippleCarryAdder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/mult4_seq_ctrl.sv
// rtl/mult4_seq_ctrl.sv - unsigned shift-add multiplier, one partial product per cycle
module mult4_seq_ctrl
    import mult4_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_acc;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_shift;
    logic               w_last;

    assign w_addend = r_q[0] ? r_m : '0;
    // Carry-out becomes the new ACC MSB, so the full product is never truncated.
    assign w_shift  = {w_cout, w_sum, r_q[WIDTH-1:1]};
    assign w_last   = (r_count == LAST);

    fourRippleCarryAdder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (r_acc),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_CALC;
            ST_CALC: begin
                busy = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m     <= a;
                        r_q     <= b;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                ST_CALC: begin
                    {r_acc, r_q} <= w_shift;
                    r_count      <= r_count + CW'(1);
                    if (w_last) r_product <= w_shift;
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// tb/tb_mult4_seq_ctrl.sv - directed vector bench for mult4_seq_ctrl
module tb_mult4_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_prod = 8'd0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
        bit         scramble;
        string      name;
    } vec_t;

    vec_t vecs[8];

    mult4_seq_ctrl #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; start is taken on the next posedge.
    task automatic run_mult(input logic [3:0] va, input logic [3:0] vb,
                            input logic [7:0] ve, input bit scr, input string nm);
        int lat;
        int bcnt;
        logic [7:0] prev;
        prev  = exp_prod;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scr) begin
            a = 4'd0;
            b = 4'd0;
        end
        lat  = 0;
        bcnt = 0;
        for (int k = 1; k <= 10; k++) begin
            if (busy) bcnt++;
            if (k == 3) chk({nm, "_hold"}, product, prev);
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_latency"}, lat, 5);
        chk({nm, "_busy_cycles"}, bcnt, 5);
        chk({nm, "_product"}, product, ve);
        exp_prod = ve;
        @(negedge clk);
        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_done_single"}, done, 0);
    endtask

    initial begin
        int nd;
        int t[3];

        vecs[0] = '{4'd13, 4'd11, 8'd143, 1'b0, "m13x11"};
        vecs[1] = '{4'd15, 4'd15, 8'd225, 1'b0, "m15x15"};
        vecs[2] = '{4'd0,  4'd9,  8'd0,   1'b0, "m0x9"};
        vecs[3] = '{4'd9,  4'd9,  8'd81,  1'b1, "m9x9_scr"};
        vecs[4] = '{4'd8,  4'd2,  8'd16,  1'b0, "m8x2"};
        vecs[5] = '{4'd1,  4'd15, 8'd15,  1'b0, "m1x15"};
        vecs[6] = '{4'd10, 4'd12, 8'd120, 1'b1, "m10x12_scr"};
        vecs[7] = '{4'd15, 4'd0,  8'd0,   1'b0, "m15x0"};

        reset = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_mult(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].scramble, vecs[i].name);
        end

        // Second start during CALC must be ignored.
        a = 4'd7; b = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                start = 1'b1; a = 4'd1; b = 4'd1;
            end else if (k == 3) begin
                start = 1'b0;
            end
            if (done) begin
                nd++;
                chk("repulse_product", product, 42);
            end
            @(negedge clk);
        end
        chk("repulse_done_count", nd, 1);
        chk("repulse_final_product", product, 42);

        // Start held high: back-to-back multiplies every 6 cycles.
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(negedge clk);
        nd = 0;
        t  = '{0, 0, 0};
        for (int c = 1; c <= 17; c++) begin
            if (done) begin
                if (nd < 3) t[nd] = c;
                nd++;
                chk("cont_product", product, 15);
            end
            if (c < 17) @(negedge clk);
        end
        start = 1'b0;
        chk("cont_done_count", nd, 3);
        chk("cont_done_t0", t[0], 5);
        chk("cont_done_t1", t[1], 11);
        chk("cont_done_t2", t[2], 17);
        @(negedge clk);
        chk("cont_idle_busy", busy, 0);

        // Reset in the second CALC cycle aborts with no done pulse.
        a = 4'd13; b = 4'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        reset = 1'b0;
        exp_prod = 8'd0;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        chk("abort_no_activity", nd, 0);

        // Start on the very first edge after reset deasserts.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_mult(4'd5, 4'd3, 8'd15, 1'b0, "post_reset_5x3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult4_seq_ctrl.md
MULT4_SEQ_CTRL -- requirements
Module: mult4_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand width in bits; product is 2*WIDTH bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  multiplicand; captured on the accepted start.
REQ-006 SHALL have port b  input  WIDTH  multiplier; captured on the accepted start.
REQ-007 SHALL have port busy  output  1  high in CALC and DONE states.
REQ-008 SHALL have port done  output  1  one-cycle pulse when product becomes valid.
REQ-009 SHALL have port product  output  2*WIDTH  unsigned a*b, registered.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, DONE.
REQ-011 SHALL, in IDLE with start=1, load M<=a, Q<=b, ACC<=0, count<=0, and go to CALC next cycle.
REQ-012 SHALL, in IDLE with start=0, remain in IDLE with product unchanged.
REQ-013 SHALL, each CALC cycle, compute {C,SUM} = ACC + (Q[0] ? M : 0) with carry-in 0 through the single shared WIDTH-bit ripple adder.
REQ-014 SHALL, in the same CALC cycle, load {ACC,Q} <= {C,SUM,Q} shifted right by one and increment count.
REQ-015 SHALL stay in CALC for exactly WIDTH cycles (count 0..WIDTH-1), then go to DONE.
REQ-016 SHALL, on the CALC-to-DONE edge, register product <= {ACC,Q} final value.
REQ-017 SHALL assert done for exactly the single DONE cycle, then return to IDLE unconditionally.
REQ-018 SHALL give latency: start accepted at edge N gives done=1 during cycle N+WIDTH+1 (cycle N+5 for WIDTH=4).
REQ-019 SHALL ignore start while busy=1; operands and progress of the current multiply are unaffected.
REQ-020 SHALL accept a start asserted in the cycle after DONE (back-to-back), giving throughput of one multiply per WIDTH+2 cycles.
REQ-021 SHALL hold product stable from the done pulse until the next done pulse; a/b changes after acceptance have no effect.
REQ-022 SHALL never drop the adder carry-out; it becomes the MSB of ACC on each shift, so 15*15 = 225 is exact.

Reset
REQ-023 SHALL, when reset=1 at a clock edge, set state=IDLE, count=0, M=Q=ACC=0, product=0, busy=0, done=0.
REQ-024 SHALL give reset priority over start and over any in-flight CALC/DONE; an aborted multiply produces no done pulse.
REQ-025 SHALL sample start on the first edge after reset deasserts.

Structure
REQ-026 SHALL place WIDTH default and the IDLE/CALC/DONE state encodings (2-bit) in the team's shared constants package.
REQ-027 SHALL instantiate exactly one sub-module, the team's existing fourRippleCarryAdder, as the only adder; no "*" operator.
REQ-028 SHALL size count as clog2(WIDTH)+1 bits so the terminal compare has no wrap ambiguity.

Verification
REQ-029 SHALL cover: reset, then start with a=13 and b=11 -> done pulses 5 cycles later, product=143 (0x8F), busy high for 5 cycles.
REQ-030 SHALL cover: a=15, b=15 -> product=225 (0xE1); a=0, b=9 -> product=0 with the same latency.
REQ-031 SHALL cover: start re-pulsed with a=1, b=1 during CALC of 7*6 -> single done, product=42, second request ignored.
REQ-032 SHALL cover: start held high continuously with a=3, b=5 -> done every 6 cycles, product=15 each time.
REQ-033 SHALL cover: reset asserted in the 2nd CALC cycle -> next cycle state IDLE, busy=0, product=0, no done pulse.
REQ-034 SHALL cover: a/b changed to 0 the cycle after acceptance of 9*9 -> product=81.
